ledarbiter: RTL and testbench

Owns the board LED bank and shares it between three requesters: the free-running bounce pattern, a software-written register and a set of hardware alert lines. The block sits between the LED bouncer and the output pins. Alerts are shown round-robin, each for a fixed hold time with a blink pattern. Software ownership is taken by writing and lapses after an idle timeout, which returns the LEDs to the bounce pattern.

---
 rtl/ledarbiter_pkg.sv | 14 +
 rtl/rrarbiter.sv | 51 +++++
 rtl/ledarbiter.sv | 170 +++++++++++++++++
 tb/tb_ledarbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledarbiter_pkg.sv
// Shared owner encodings and arbiter state type for the LED bank.
package ledarbiter_pkg;

   localparam logic [1:0] OWN_AUTO  = 2'd0;
   localparam logic [1:0] OWN_SW    = 2'd1;
   localparam logic [1:0] OWN_ALERT = 2'd2;

   typedef enum logic [1:0] {
      ST_AUTO  = 2'd0,
      ST_SW    = 2'd1,
      ST_ALERT = 2'd2
   } state_t;

endpackage

// File: rtl/rrarbiter.sv
// Round-robin arbiter: combinational search starting after the last grant,
// with the last-grant pointer held in a register updated on acceptance.
module rrarbiter #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         update,
   output logic [N-1:0] grant,
   output logic         any
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] last;
   logic [PW-1:0] idx;
   logic [PW-1:0] gidx;

   always_comb begin
      grant = '0;
      idx   = '0;
      for (int unsigned off = 1; off <= N; off++) begin
         idx = PW'((32'(last) + off) % N);
         if (grant == '0 && req[idx]) begin
            grant[idx] = 1'b1;
         end
      end
   end

   always_comb begin
      gidx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (grant[k]) begin
            gidx = PW'(k);
         end
      end
   end

   assign any = |req;

   // Reset to the top index so that index 0 is the first one searched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= PW'(N - 1);
      end else if (update && any) begin
         last <= gidx;
      end
   end

endmodule

// File: rtl/ledarbiter.sv
// LED bank owner: shares the LEDs between the bounce pattern, a software
// register with idle timeout, and round-robin blinking hardware alerts.
module ledarbiter
   import ledarbiter_pkg::*;
#(
   parameter int unsigned NLEDS     = 8,
   parameter int unsigned NALERT    = 4,
   parameter int unsigned HOLDBITS  = 24,
   parameter int unsigned SWTOBITS  = 27,
   parameter int unsigned BLINKBITS = 22
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [NLEDS-1:0]  i_auto_leds,
   input  logic              i_sw_stb,
   input  logic              i_sw_mode,
   input  logic [NLEDS-1:0]  i_sw_leds,
   input  logic [NALERT-1:0] i_alert,
   output logic [NLEDS-1:0]  o_leds,
   output logic [1:0]        o_owner,
   output logic [NALERT-1:0] o_grant
);

   state_t state, state_next;

   logic [NALERT-1:0]   pending;
   logic [NALERT-1:0]   req;
   logic [NALERT-1:0]   pick;
   logic [NALERT-1:0]   grant_q;
   logic                arb_any;
   logic                take;

   logic [HOLDBITS-1:0] hold_ctr;
   logic                hold_wrap;

   logic [SWTOBITS-1:0] sw_timer;
   logic                sw_active;
   logic                sw_active_next;
   logic                sw_wrap;
   logic [NLEDS-1:0]    sw_val;

   logic [BLINKBITS:0]  blink_ctr;
   logic                blink;

   logic [NLEDS-1:0]    led_alert;
   logic [NLEDS-1:0]    leds_next;
   logic [1:0]          owner_next;
   logic [NALERT-1:0]   grant_next;

   // Software ownership; a strobe always beats a coincident timer wrap.
   always_comb begin
      sw_wrap        = sw_active && (sw_timer == '1) && !i_sw_stb;
      sw_active_next = i_sw_stb ? i_sw_mode : (sw_active && !sw_wrap);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sw_active <= 1'b0;
         sw_timer  <= '0;
         sw_val    <= '0;
      end else begin
         sw_active <= sw_active_next;
         if (i_sw_stb) begin
            sw_timer <= '0;
         end else if (sw_active) begin
            sw_timer <= sw_timer + 1'b1;
         end
         if (i_sw_stb && i_sw_mode) begin
            sw_val <= i_sw_leds;
         end
      end
   end

   // At slot end the live alert lines join the search so a request raised
   // in the final cycle competes in that same arbitration.
   always_comb begin
      hold_wrap = (hold_ctr == '1);
      req       = (state == ST_ALERT) ? (pending | i_alert) : pending;
   end

   rrarbiter #(
      .N(NALERT)
   ) u_rr (
      .clk    (i_clk),
      .rst    (i_reset),
      .req    (req),
      .update (take),
      .grant  (pick),
      .any    (arb_any)
   );

   always_comb begin
      state_next = state;
      take       = 1'b0;
      case (state)
         ST_AUTO, ST_SW: begin
            if (arb_any) begin
               state_next = ST_ALERT;
               take       = 1'b1;
            end else begin
               state_next = sw_active_next ? ST_SW : ST_AUTO;
            end
         end
         ST_ALERT: begin
            if (hold_wrap) begin
               if (arb_any) begin
                  take = 1'b1;
               end else begin
                  state_next = sw_active_next ? ST_SW : ST_AUTO;
               end
            end
         end
         default: state_next = ST_AUTO;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= ST_AUTO;
         pending   <= '0;
         grant_q   <= '0;
         hold_ctr  <= '0;
         blink_ctr <= '0;
      end else begin
         state     <= state_next;
         pending   <= (pending | i_alert) & ~(take ? pick : '0);
         blink_ctr <= blink_ctr + 1'b1;
         if (take) begin
            grant_q  <= pick;
            hold_ctr <= '0;
         end else if (state == ST_ALERT) begin
            hold_ctr <= hold_ctr + 1'b1;
         end
      end
   end

   always_comb begin
      blink                     = blink_ctr[BLINKBITS];
      led_alert                 = '0;
      led_alert[NALERT-1:0]     = grant_q;
      leds_next                 = i_auto_leds;
      owner_next                = OWN_AUTO;
      grant_next                = '0;
      case (state)
         ST_SW: begin
            leds_next  = sw_val;
            owner_next = OWN_SW;
         end
         ST_ALERT: begin
            leds_next  = blink ? '1 : led_alert;
            owner_next = OWN_ALERT;
            grant_next = grant_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_leds  <= '0;
         o_owner <= OWN_AUTO;
         o_grant <= '0;
      end else begin
         o_leds  <= leds_next;
         o_owner <= owner_next;
         o_grant <= grant_next;
      end
   end

endmodule

// File: tb/tb_ledarbiter.sv
// Bench for ledarbiter: vector table, directed multi-cycle sequences and
// random traffic against a behavioural owner/slot model.
module tb_ledarbiter;

   localparam int NL = 8;
   localparam int NA = 4;
   localparam int HB = 3;
   localparam int SB = 4;
   localparam int BB = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NL-1:0] auto_leds = '0;
   logic          stb = 1'b0;
   logic          mode = 1'b0;
   logic [NL-1:0] sw_leds = '0;
   logic [NA-1:0] alert = '0;
   logic [NL-1:0] o_leds;
   logic [1:0]    o_owner;
   logic [NA-1:0] o_grant;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ledarbiter #(
      .NLEDS(NL), .NALERT(NA), .HOLDBITS(HB), .SWTOBITS(SB), .BLINKBITS(BB)
   ) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_auto_leds (auto_leds),
      .i_sw_stb    (stb),
      .i_sw_mode   (mode),
      .i_sw_leds   (sw_leds),
      .i_alert     (alert),
      .o_leds      (o_leds),
      .o_owner     (o_owner),
      .o_grant     (o_grant)
   );

   // ---------------- behavioural model ----------------
   int           m_state;     // 0 auto, 1 sw, 2 alert
   bit           m_pend[NA];
   int           m_last;
   int           m_gidx;
   int           m_slot;
   int           m_idle;
   int           m_blink;
   bit           m_sw_on;
   logic [NL-1:0] m_sw_val;
   logic [NL-1:0] e_leds;
   logic [1:0]    e_owner;
   logic [NA-1:0] e_grant;

   task automatic model_reset();
      m_state = 0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_last   = NA - 1;
      m_gidx   = 0;
      m_slot   = 0;
      m_idle   = 0;
      m_blink  = 0;
      m_sw_on  = 1'b0;
      m_sw_val = '0;
   endtask

   function automatic int pick_next();
      for (int off = 1; off <= NA; off++) begin
         int k = (m_last + off) % NA;
         if (m_pend[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_step();
      int  k = -1;
      bit  on_n;
      bit  wrap;
      int  blink = (m_blink >> BB) & 1;
      case (m_state)
         1: begin e_leds = m_sw_val; e_owner = 2'd1; e_grant = '0; end
         2: begin
            e_leds  = blink ? 8'hff : 8'(1 << m_gidx);
            e_owner = 2'd2;
            e_grant = 4'(1 << m_gidx);
         end
         default: begin e_leds = auto_leds; e_owner = 2'd0; e_grant = '0; end
      endcase
      wrap = m_sw_on && (m_idle == (1 << SB) - 1) && !stb;
      if (stb) begin
         m_idle = 0;
         on_n   = mode;
         if (mode) m_sw_val = sw_leds;
      end else begin
         if (m_sw_on) m_idle = (m_idle + 1) % (1 << SB);
         on_n = m_sw_on && !wrap;
      end
      if (m_state != 2) begin
         k = pick_next();
         if (k < 0) m_state = on_n ? 1 : 0;
      end else if (m_slot == (1 << HB) - 1) begin
         for (int i = 0; i < NA; i++) if (alert[i]) m_pend[i] = 1'b1;
         k = pick_next();
         if (k < 0) m_state = on_n ? 1 : 0;
      end else begin
         m_slot++;
      end
      for (int i = 0; i < NA; i++) if (alert[i]) m_pend[i] = 1'b1;
      if (k >= 0) begin
         m_state   = 2;
         m_gidx    = k;
         m_last    = k;
         m_slot    = 0;
         m_pend[k] = 1'b0;
      end
      m_sw_on = on_n;
      m_blink = (m_blink + 1) % (1 << (BB + 1));
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("owner", 32'(o_owner), 32'(e_owner));
      check("leds", 32'(o_leds), 32'(e_leds));
      check("grant", 32'(o_grant), 32'(e_grant));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("reset_leds", 32'(o_leds), 32'h0);
      check("reset_owner", 32'(o_owner), 32'h0);
      check("reset_grant", 32'(o_grant), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic          stb;
      logic          mode;
      logic [NL-1:0] sw;
      logic [NA-1:0] al;
      logic [NL-1:0] au;
      logic [1:0]    owner;
      logic [NL-1:0] leds;
      logic [NA-1:0] grant;
   } vec_t;

   vec_t       tbl[13];
   logic [3:0] seq[$];
   logic [3:0] g[25];
   logic [3:0] prev;
   int         cnt, cnt_a, cnt_b;
   bit         done;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // expected outputs are the registered values after the vector's edge
      tbl[0]  = '{1'b0, 1'b0, 8'h00, 4'h0, 8'h5a, 2'd0, 8'h5a, 4'h0};
      tbl[1]  = '{1'b0, 1'b0, 8'h00, 4'h0, 8'ha5, 2'd0, 8'ha5, 4'h0};
      tbl[2]  = '{1'b1, 1'b1, 8'hc3, 4'h0, 8'h5a, 2'd0, 8'h5a, 4'h0};
      tbl[3]  = '{1'b0, 1'b0, 8'h00, 4'h0, 8'h5a, 2'd1, 8'hc3, 4'h0};
      tbl[4]  = '{1'b1, 1'b0, 8'h00, 4'h0, 8'h5a, 2'd1, 8'hc3, 4'h0};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 4'h0, 8'h3c, 2'd0, 8'h3c, 4'h0};
      tbl[6]  = '{1'b1, 1'b1, 8'h81, 4'h0, 8'h3c, 2'd0, 8'h3c, 4'h0};
      tbl[7]  = '{1'b1, 1'b1, 8'h7e, 4'h0, 8'h3c, 2'd1, 8'h81, 4'h0};
      tbl[8]  = '{1'b0, 1'b0, 8'h00, 4'h0, 8'h3c, 2'd1, 8'h7e, 4'h0};
      tbl[9]  = '{1'b1, 1'b0, 8'hff, 4'h0, 8'h3c, 2'd1, 8'h7e, 4'h0};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 2'd0, 8'h00, 4'h0};
      tbl[11] = '{1'b1, 1'b0, 8'h00, 4'h0, 8'h11, 2'd0, 8'h11, 4'h0};
      tbl[12] = '{1'b0, 1'b0, 8'h00, 4'h0, 8'h22, 2'd0, 8'h22, 4'h0};

      #2;
      model_reset();
      do_reset();

      for (int i = 0; i < 13; i++) begin
         stb = tbl[i].stb; mode = tbl[i].mode; sw_leds = tbl[i].sw;
         alert = tbl[i].al; auto_leds = tbl[i].au;
         tick();
         check("tbl_owner", 32'(o_owner), 32'(tbl[i].owner));
         check("tbl_leds", 32'(o_leds), 32'(tbl[i].leds));
         check("tbl_grant", 32'(o_grant), 32'(tbl[i].grant));
      end
      stb = 0; mode = 0; alert = '0; auto_leds = 8'h5a;

      // software timeout: ownership visible for 2^SB cycles
      cnt = 0;
      for (int i = 0; i <= 30; i++) begin
         stb = (i == 0); mode = 1'b1; sw_leds = 8'hc3;
         tick();
         if (i == 1) check("sw_leds_c3", 32'(o_leds), 32'hc3);
         if (o_owner == 2'd1) cnt++;
      end
      check("sw_timeout_span", 32'(cnt), 32'd16);

      // second write at cycle 10 extends ownership
      cnt = 0;
      for (int i = 0; i <= 40; i++) begin
         stb = (i == 0 || i == 10); mode = 1'b1; sw_leds = 8'hc3;
         tick();
         if (o_owner == 2'd1) cnt++;
      end
      check("sw_extend_span", 32'(cnt), 32'd26);

      // strobe on the exact timer wrap keeps ownership
      for (int i = 0; i <= 25; i++) begin
         stb = (i == 0 || i == 16); mode = 1'b1; sw_leds = 8'h99;
         tick();
      end
      check("wrap_strobe_owner", 32'(o_owner), 32'd1);
      stb = 1'b1; mode = 1'b0; tick();
      stb = 1'b0; tick();
      check("release_owner", 32'(o_owner), 32'd0);

      // round robin on a one-cycle pulse of 1010
      alert = 4'b1010; tick(); alert = '0;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         g[i] = o_grant;
         if (o_grant == 4'b0010) cnt_a++;
         if (o_grant == 4'b1000) cnt_b++;
      end
      check("rr_first_grant", 32'(g[1]), 32'h2);
      check("rr_second_grant", 32'(g[9]), 32'h8);
      check("rr_after_drain", 32'(g[17]), 32'h0);
      check("rr_slot_a", 32'(cnt_a), 32'd8);
      check("rr_slot_b", 32'(cnt_b), 32'd8);
      check("rr_owner_end", 32'(o_owner), 32'd0);

      // held alerts 0 and 2 alternate
      alert = 4'b0101;
      prev  = o_grant;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (o_grant != prev && o_grant != 4'h0) seq.push_back(o_grant);
         prev = o_grant;
      end
      check("held_seq_len", 32'(seq.size() >= 4), 32'd1);
      if (seq.size() >= 4) begin
         check("held_seq0", 32'(seq[0]), 32'h1);
         check("held_seq1", 32'(seq[1]), 32'h4);
         check("held_seq2", 32'(seq[2]), 32'h1);
         check("held_seq3", 32'(seq[3]), 32'h4);
      end
      alert = '0;
      done  = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         tick();
         if (o_owner == 2'd0) done = 1'b1;
      end
      check("held_drain", 32'(done), 32'd1);

      // software write during an alert slot applies after drain
      stb = 1'b1; mode = 1'b1; sw_leds = 8'h55; tick();
      stb = 1'b0; tick(); tick();
      alert = 4'b0100; tick(); alert = '0;
      repeat (3) tick();
      stb = 1'b1; mode = 1'b1; sw_leds = 8'h0f; tick(); stb = 1'b0;
      check("swalert_mid_owner", 32'(o_owner), 32'd2);
      repeat (12) tick();
      check("swalert_owner", 32'(o_owner), 32'd1);
      check("swalert_leds", 32'(o_leds), 32'h0f);

      // asynchronous reset in the middle of a slot
      alert = 4'b0001; tick(); alert = '0;
      repeat (4) tick();
      check("preslot_owner", 32'(o_owner), 32'd2);
      do_reset();
      auto_leds = 8'h5a; tick();
      check("post_reset_leds", 32'(o_leds), 32'h5a);

      // random traffic
      begin
         logic [NA-1:0] held = '0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0)
               held = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            alert     = held | (($urandom_range(0, 24) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
            stb       = ($urandom_range(0, 11) == 0);
            mode      = ($urandom_range(0, 3) != 0);
            sw_leds   = 8'($urandom);
            auto_leds = 8'($urandom);
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
